hw_accum_double128: RTL
=======================

Name: hw_accum_double128

Overview:
- Downstream consumer of the double-column 128-bit compressor.
- Accumulates the 9-bit per-beat compressor result over a frame of beats and emits one Hamming-weight total per frame on a valid/ready output.
- Carries the beat's valid/last sideband through a delay line matched to the compressor latency, so the sideband aligns with comp_out.
- Holds up to two completed totals so that short downstream stalls never drop a frame.

Parameters:
- COMP_LAT, 2: pipeline latency of the compressor, in cycles from column capture to comp_out; range 0..8.
- MAX_BEATS, 256: maximum beats per frame; must be a power of 2, at least 2.
- ACC_W, 9+$clog2(MAX_BEATS) (17): accumulator and output sum width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat presented to the compressor this cycle (same cycle as in_col0/in_col1).
- in_last  in  1  last beat of frame; qualified by in_valid.
- comp_out  in  9  compressor result, valid COMP_LAT cycles after its beat.
- sum_data  out  ACC_W  frame total.
- sum_beats  out  $clog2(MAX_BEATS)+1  beat count of that frame.
- sum_valid  out  1  head result available.
- sum_ready  in  1  consumer accepts the head result.
- ovf_err  out  1  sticky: a completed frame was dropped because both result slots were full.
- sat_err  out  1  sticky: a frame exceeded MAX_BEATS, or its sum saturated.

Behaviour:
- Reset (asynchronous, on rst_n low): delay line cleared; accumulator 0; beat counter 0; both result slots empty; sum_valid=0; sum_data=0; sum_beats=0; ovf_err=0; sat_err=0.
- Reset mid-frame discards the partial frame and any buffered results.
- Delay line:
  - {in_valid, in_last} are shifted through COMP_LAT registers, giving {d_valid, d_last}.
  - With COMP_LAT=0 the path is a wire.
  - comp_out is sampled only when d_valid=1.
- Accumulate (d_valid=1):
  - acc_next = acc + comp_out, zero-extended.
  - beats_next = beats + 1.
  - If the sum would exceed 2^ACC_W-1, clamp to all-ones and set sat_err.
  - If beats_next > MAX_BEATS, set sat_err and keep adding; the count saturates at MAX_BEATS.
- Frame close (d_valid & d_last):
  - The final total (acc+comp_out) and beat count are pushed into the result FIFO in the same cycle.
  - acc and beats reset to 0 on the next edge.
  - Back-to-back frames are allowed; the next beat may arrive on the following cycle.
- d_valid=0 cycles leave acc and beats unchanged. Gaps inside a frame are allowed.
- Result FIFO:
  - Two entries.
  - sum_valid = not empty; sum_data and sum_beats come from the head entry.
  - Pop when sum_valid & sum_ready.
  - Push and pop in the same cycle is allowed at any occupancy, including full: occupancy is unchanged and the new entry is queued behind the remaining one.
  - Push when full without a pop: the new result is dropped, ovf_err is set, and the FIFO contents are unchanged.
  - Head outputs hold stable while sum_valid=1 and sum_ready=0.
- Output timing: sum_valid rises the cycle after the closing d_valid&d_last, so end-to-end latency from the last in_valid is COMP_LAT+1 cycles.
- Sticky flags clear only on reset.
- No input backpressure: the compressor pipeline cannot stall, so the block has no in_ready.

Test Plan:
- Single-beat frame, COMP_LAT=2: in_valid=in_last=1 at cycle 0, comp_out=384 at cycle 2 -> sum_valid=1 at cycle 3 with sum_data=384, sum_beats=1.
- Four-beat frame with one idle gap, comp_out=10,20,0,5, sum_ready=1 -> exactly one result, sum_data=35, sum_beats=4; sum_valid is high for one cycle.
- Three back-to-back single-beat frames (100, 200, 300) with sum_ready=0 -> first two are held in order (100, then 200), ovf_err=1; after sum_ready=1 the outputs are 100 then 200, and 300 is never seen.
- FIFO full while a new frame closes and sum_ready=1 in that same cycle -> no overflow; the order of results is preserved.
- MAX_BEATS=4, five beats with the last on beat 5 -> sat_err=1, sum_beats=4, sum_data equals the true sum (no clamp needed).
- rst_n pulsed low asynchronously mid-frame after two beats, then a new one-beat frame of 7 -> all outputs return to their reset values immediately; the next result is sum_data=7, sum_beats=1.

Source files
------------

// File: rtl/hw_accum_double128.sv
`default_nettype none
// ============================================================================
// hw_accum_double128 : per-frame Hamming-weight accumulator, 2-entry result FIFO
// Rev 1.0
// ============================================================================
module hw_accum_double128 #(
  parameter int COMP_LAT  = 2,
  parameter int MAX_BEATS = 256,
  parameter int ACC_W     = 9 + $clog2(MAX_BEATS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [8:0]                     comp_out,
  output logic [ACC_W-1:0]               sum_data,
  output logic [$clog2(MAX_BEATS):0]     sum_beats,
  output logic                           sum_valid,
  input  logic                           sum_ready,
  output logic                           ovf_err,
  output logic                           sat_err
);

  localparam int BEAT_W = $clog2(MAX_BEATS) + 1;

  logic d_valid;
  logic d_last;

  // Sideband delay matched to the compressor pipeline so it lines up with comp_out.
  generate
    if (COMP_LAT == 0) begin : g_dly_wire
      assign d_valid = in_valid;
      assign d_last  = in_last;
    end else begin : g_dly_regs
      logic [COMP_LAT-1:0] vld_q;
      logic [COMP_LAT-1:0] lst_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          lst_q <= '0;
        end else begin
          vld_q[0] <= in_valid;
          lst_q[0] <= in_last;
          for (int i = 1; i < COMP_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            lst_q[i] <= lst_q[i-1];
          end
        end
      end
      assign d_valid = vld_q[COMP_LAT-1];
      assign d_last  = lst_q[COMP_LAT-1];
    end
  endgenerate

  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [ACC_W:0]    sum_wide;
  logic [ACC_W-1:0]  acc_sum;
  logic [BEAT_W-1:0] beats_inc;
  logic              beat_full;
  logic              sat_set;
  logic              push;
  logic              pop;

  logic [ACC_W-1:0]  data0_q,  data0_d,  data1_q,  data1_d;
  logic [BEAT_W-1:0] beats0_q, beats0_d, beats1_q, beats1_d;
  logic [1:0]        cnt_q,    cnt_d;
  logic              ovf_q,    ovf_d;
  logic              sat_q,    sat_d;

  assign sum_wide  = {1'b0, acc_q} + {{(ACC_W-8){1'b0}}, comp_out};
  assign acc_sum   = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign beat_full = (beats_q == BEAT_W'(MAX_BEATS));
  assign beats_inc = beat_full ? beats_q : beats_q + BEAT_W'(1);
  assign sat_set   = d_valid & (sum_wide[ACC_W] | beat_full);
  assign push      = d_valid & d_last;
  assign pop       = (cnt_q != 2'd0) & sum_ready;

  always_comb begin
    acc_d   = acc_q;
    beats_d = beats_q;
    sat_d   = sat_q | sat_set;
    if (d_valid) begin
      if (d_last) begin
        acc_d   = '0;
        beats_d = '0;
      end else begin
        acc_d   = acc_sum;
        beats_d = beats_inc;
      end
    end
  end

  // Head is slot 0; a pop shifts slot 1 forward and a simultaneous push lands behind it.
  always_comb begin
    data0_d  = data0_q;
    data1_d  = data1_q;
    beats0_d = beats0_q;
    beats1_d = beats1_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (pop && push) begin
      if (cnt_q == 2'd2) begin
        data0_d  = data1_q;
        beats0_d = beats1_q;
        data1_d  = acc_sum;
        beats1_d = beats_inc;
      end else begin
        data0_d  = acc_sum;
        beats0_d = beats_inc;
      end
    end else if (pop) begin
      data0_d  = data1_q;
      beats0_d = beats1_q;
      cnt_d    = cnt_q - 2'd1;
    end else if (push) begin
      case (cnt_q)
        2'd0: begin
          data0_d  = acc_sum;
          beats0_d = beats_inc;
          cnt_d    = 2'd1;
        end
        2'd1: begin
          data1_d  = acc_sum;
          beats1_d = beats_inc;
          cnt_d    = 2'd2;
        end
        default: ovf_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      beats_q  <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      beats0_q <= '0;
      beats1_q <= '0;
      cnt_q    <= 2'd0;
      ovf_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      beats_q  <= beats_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      beats0_q <= beats0_d;
      beats1_q <= beats1_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sat_q    <= sat_d;
    end
  end

  assign sum_valid = (cnt_q != 2'd0);
  assign sum_data  = data0_q;
  assign sum_beats = beats0_q;
  assign ovf_err   = ovf_q;
  assign sat_err   = sat_q;

endmodule
`default_nettype wire
